// File: rtl/rv_mem_pkg.sv
// Shared memory-stage definitions: opcodes, funct3 codes,
// LSU state encoding and the access-size mask helper.
package rv_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

  // Byte mask of an access of the size encoded in f3[1:0].
  function automatic logic [3:0] size_mask(
    input logic [2:0] f3
  );
    logic [3:0] m;
    case (f3[1:0])
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Load result formatter: shifts the 64-bit read buffer by the byte offset
// and sign/zero-extends per funct3. Ports: lbuf, off, funct3 in; result out.
module load_aligner
  import rv_mem_pkg::*;
(
  input  logic [63:0] lbuf,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] x;

  assign x = lbuf[{1'b0, off, 3'b000} +: 32];

  always_comb begin
    result = x;
    case (funct3)
      F3_B:    result = {{24{x[7]}}, x[7:0]};
      F3_H:    result = {{16{x[15]}}, x[15:0]};
      F3_BU:   result = {24'b0, x[7:0]};
      F3_HU:   result = {16'b0, x[15:0]};
      default: result = x;
    endcase
  end

endmodule

// File: rtl/load_store_initiator.sv
// Memory-stage initiator: execute in (valid/ready), req/gnt/rvalid data port,
// writeback out (valid/ready). Splits misaligned accesses into two words.
module load_store_initiator
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ir,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       ir_out,
  output logic [31:0]       rd_out,
  output logic [31:0]       a_out,
  output logic [31:0]       pc_out,
  output logic              err_out
);

  lsu_state_t state;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_ld;
  logic        is_st;
  logic        ld_ok;
  logic        st_ok;
  logic        mem_op;
  logic        illegal;
  logic [7:0]  m8;
  logic [63:0] wide;
  logic        split;

  logic        ld_q;
  logic        split_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be1_q;
  logic [31:0] wd1_q;
  logic [63:0] lbuf;
  logic [63:0] nbuf;
  logic [31:0] ld_res;

  assign opc   = ir[6:0];
  assign f3    = ir[14:12];
  assign is_ld = (opc == OP_LOAD);
  assign is_st = (opc == OP_STORE);

  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    unique case (1'b1)
      is_ld: ld_ok = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      is_st: st_ok = f3 inside {F3_B, F3_H, F3_W};
      default: ;
    endcase
  end

  assign mem_op  = ld_ok | st_ok;
  assign illegal = (is_ld | is_st) & ~mem_op;
  assign m8      = {4'b0, size_mask(f3)} << addr[1:0];
  assign wide    = {32'b0, wdata} << {addr[1:0], 3'b000};
  assign split   = |m8[7:4];

  assign in_ready = (state == IDLE);

  // Merge the word arriving this cycle so the result can be
  // registered on the same edge that captures it.
  assign nbuf = (state == WAIT0) ? {lbuf[63:32], mem_rdata}
                                 : {mem_rdata, lbuf[31:0]};

  load_aligner u_align (
    .lbuf   (nbuf),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ld_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'b0;
      out_valid <= 1'b0;
      ir_out    <= 32'b0;
      rd_out    <= 32'b0;
      a_out     <= 32'b0;
      pc_out    <= 32'b0;
      err_out   <= 1'b0;
      ld_q      <= 1'b0;
      split_q   <= 1'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
      be1_q     <= 4'b0;
      wd1_q     <= 32'b0;
      lbuf      <= 64'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          ir_out  <= ir;
          a_out   <= addr;
          pc_out  <= pc;
          rd_out  <= 32'b0;
          err_out <= illegal;
          ld_q    <= ld_ok;
          split_q <= split;
          f3_q    <= f3;
          off_q   <= addr[1:0];
          be1_q   <= m8[7:4];
          wd1_q   <= wide[63:32];
          if (mem_op) begin
            state     <= REQ0;
            mem_req   <= 1'b1;
            mem_we    <= st_ok;
            mem_addr  <= addr[ADDR_W+1:2];
            mem_be    <= m8[3:0];
            mem_wdata <= wide[31:0];
          end else begin
            state     <= RESP;
            out_valid <= 1'b1;
          end
        end
        REQ0: if (mem_gnt) begin
          if (ld_q) begin
            mem_req <= 1'b0;
            state   <= WAIT0;
          end else if (split_q) begin
            state     <= REQ1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_be    <= be1_q;
            mem_wdata <= wd1_q;
          end else begin
            mem_req   <= 1'b0;
            state     <= RESP;
            out_valid <= 1'b1;
          end
        end
        WAIT0: if (mem_rvalid) begin
          lbuf[31:0] <= mem_rdata;
          if (split_q) begin
            state    <= REQ1;
            mem_req  <= 1'b1;
            mem_addr <= mem_addr + ADDR_W'(1);
            mem_be   <= be1_q;
          end else begin
            state     <= RESP;
            out_valid <= 1'b1;
            rd_out    <= ld_res;
          end
        end
        REQ1: if (mem_gnt) begin
          mem_req <= 1'b0;
          if (ld_q) begin
            state <= WAIT1;
          end else begin
            state     <= RESP;
            out_valid <= 1'b1;
          end
        end
        WAIT1: if (mem_rvalid) begin
          lbuf[63:32] <= mem_rdata;
          state       <= RESP;
          out_valid   <= 1'b1;
          rd_out      <= ld_res;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_initiator.sv
// Scoreboard bench for load_store_initiator: byte-level reference memory
// predicts word accesses and writeback results; monitors compare.
module tb_load_store_initiator;

  localparam int ADDR_W = 16;
  localparam int BMASK  = (1 << (ADDR_W + 2)) - 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       ir;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       pc;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       ir_out;
  logic [31:0]       rd_out;
  logic [31:0]       a_out;
  logic [31:0]       pc_out;
  logic              err_out;

  load_store_initiator #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ir         (ir),
    .addr       (addr),
    .wdata      (wdata),
    .pc         (pc),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ir_out     (ir_out),
    .rd_out     (rd_out),
    .a_out      (a_out),
    .pc_out     (pc_out),
    .err_out    (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] pc;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] wa;
    logic [3:0]        be;
    logic              we;
    logic [31:0]       wd;
  } acc_t;

  exp_t expq[$];
  acc_t accq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic [7:0] mem_b [int];
  logic [7:0] ref_b [int];
  bit   fast = 0;
  bit   hold_rv = 0;
  bit   force_rv = 0;
  int   gnt_hold = 0;
  int   rdy_hold = 0;
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [6:0] alu_op [3] = '{7'h33, 7'h13, 7'h63};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(int a);
    return 8'(a * 37 + 5);
  endfunction

  function automatic logic [7:0] rdm(int a);
    return mem_b.exists(a) ? mem_b[a] : dflt(a);
  endfunction

  function automatic logic [7:0] rdr(int a);
    return ref_b.exists(a) ? ref_b[a] : dflt(a);
  endfunction

  function automatic logic [31:0] lanes(logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, want, $time);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @%0t", nm, $time);
  endtask

  // Reference: walk the n bytes of the access, bin them into words.
  task automatic model(logic [31:0] i, logic [31:0] a,
                       logic [31:0] wd, logic [31:0] p, int t0);
    logic [6:0]  op;
    logic [2:0]  f;
    bit          ld;
    bit          st;
    int          n;
    int          w0;
    int          nacc;
    logic [31:0] v;
    exp_t        e;
    acc_t        ac [2];
    op = i[6:0];
    f  = i[14:12];
    ld = (op == 7'h03) && (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st = (op == 7'h23) && (f <= 3'd2);
    n  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e.ir  = i;
    e.a   = a;
    e.pc  = p;
    e.rd  = 32'b0;
    e.err = (op == 7'h03 || op == 7'h23) && !ld && !st;
    e.t0  = t0;
    nacc  = 0;
    v     = 32'b0;
    if (ld || st) begin
      w0 = int'((a & 32'(BMASK)) >> 2);
      for (int s = 0; s < 2; s++) begin
        ac[s].wa = ADDR_W'(w0 + s);
        ac[s].be = 4'b0;
        ac[s].we = st;
        ac[s].wd = 32'b0;
      end
      for (int k = 0; k < n; k++) begin
        int b;
        int sl;
        int ln;
        b  = int'((a + 32'(k)) & 32'(BMASK));
        sl = ((b >> 2) == w0) ? 0 : 1;
        ln = b & 3;
        ac[sl].be[ln] = 1'b1;
        ac[sl].wd[8*ln +: 8] = wd[8*k +: 8];
        if (st) ref_b[b] = wd[8*k +: 8];
        else v[8*k +: 8] = rdr(b);
      end
      nacc = (ac[1].be != 4'b0) ? 2 : 1;
      accq.push_back(ac[0]);
      if (nacc == 2) accq.push_back(ac[1]);
      if (ld) begin
        case (f)
          3'd0:    e.rd = {{24{v[7]}}, v[7:0]};
          3'd1:    e.rd = {{16{v[15]}}, v[15:0]};
          3'd4:    e.rd = {24'b0, v[7:0]};
          3'd5:    e.rd = {16'b0, v[15:0]};
          default: e.rd = v;
        endcase
      end
    end
    if (fast && gnt_hold == 0)
      e.lat = !(ld || st) ? 1 : ld ? 1 + 2 * nacc : 1 + nacc;
    else
      e.lat = -1;
    expq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(logic [31:0] i, logic [31:0] a,
                       logic [31:0] wd, logic [31:0] p);
    int t;
    t = 0;
    in_valid = 1'b1;
    ir = i;
    addr = a;
    wdata = wd;
    pc = p;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail("issue_timeout");
      in_valid = 1'b0;
      return;
    end
    model(i, a, wd, p, cyc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || accq.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) fail("drain_timeout");
  endtask

  task automatic preload_w(int a, logic [31:0] v);
    for (int l = 0; l < 4; l++) begin
      mem_b[a + l] = v[8*l +: 8];
      ref_b[a + l] = v[8*l +: 8];
    end
  endtask

  task automatic preload_b(int a, logic [7:0] v);
    mem_b[a] = v;
    ref_b[a] = v;
  endtask

  // Memory responder and request-side checker.
  initial begin
    bit                rd_pend;
    int                rd_dly;
    int                rd_w;
    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_be;
    logic              g_we;
    logic [31:0]       g_wd;
    bit                s_valid;
    logic [ADDR_W-1:0] s_addr;
    logic [3:0]        s_be;
    logic              s_we;
    logic [31:0]       s_wd;
    acc_t              e;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'b0;
    rd_pend = 0;
    rd_dly = 0;
    rd_w = 0;
    s_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        rd_pend = 0;
        s_valid = 0;
      end else begin
        if (s_valid) begin
          chk("req_held", mem_req, 1'b1);
          chk("req_addr_stable", 32'(mem_addr), 32'(s_addr));
          chk("req_be_stable", {mem_we, mem_be}, {s_we, s_be});
          chk("req_wd_stable", mem_wdata, s_wd);
        end
        if (mem_gnt) begin
          if (accq.size() == 0) begin
            fail("unexpected_access");
          end else begin
            e = accq.pop_front();
            chk("acc_addr", 32'(g_addr), 32'(e.wa));
            chk("acc_be", 32'(g_be), 32'(e.be));
            chk("acc_we", 32'(g_we), 32'(e.we));
            if (e.we)
              chk("acc_wdata", g_wd & lanes(e.be), e.wd & lanes(e.be));
          end
          if (g_we) begin
            for (int l = 0; l < 4; l++)
              if (g_be[l]) mem_b[int'(g_addr) * 4 + l] = g_wd[8*l +: 8];
          end else begin
            rd_pend = 1;
            rd_dly = fast ? 0 : $urandom_range(0, 3);
            rd_w = int'(g_addr);
          end
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (rd_pend) begin
          if (!hold_rv) begin
            if (rd_dly == 0) begin
              mem_rvalid = 1'b1;
              mem_rdata = {rdm(rd_w*4+3), rdm(rd_w*4+2),
                           rdm(rd_w*4+1), rdm(rd_w*4)};
              rd_pend = 0;
            end else begin
              rd_dly--;
            end
          end
        end else if (force_rv) begin
          mem_rvalid = 1'b1;
        end else if (!mem_req && !fast && $urandom_range(0, 7) == 0) begin
          mem_rvalid = 1'b1;
        end
        if (mem_req && !rd_pend) begin
          if (gnt_hold > 0) begin
            gnt_hold--;
          end else if (fast || $urandom_range(0, 2) != 0) begin
            mem_gnt = 1'b1;
            g_addr = mem_addr;
            g_be = mem_be;
            g_we = mem_we;
            g_wd = mem_wdata;
          end
        end
        s_valid = mem_req && !mem_gnt;
        s_addr = mem_addr;
        s_be = mem_be;
        s_we = mem_we;
        s_wd = mem_wdata;
      end
    end
  end

  // Writeback-side monitor.
  initial begin
    bit          prev_ov;
    bit          prev_rdy;
    logic [31:0] h_ir;
    logic [31:0] h_rd;
    logic [31:0] h_a;
    logic [31:0] h_pc;
    exp_t        e;
    out_ready = 1'b0;
    prev_ov = 0;
    prev_rdy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_ready = 1'b0;
        prev_ov = 0;
        prev_rdy = 0;
      end else begin
        if (prev_ov && !prev_rdy) begin
          chk("out_valid_held", out_valid, 1'b1);
          chk("hold_ir", ir_out, h_ir);
          chk("hold_rd", rd_out, h_rd);
          chk("hold_a", a_out, h_a);
          chk("hold_pc", pc_out, h_pc);
        end
        if (out_valid) begin
          chk("in_ready_busy", in_ready, 1'b0);
          if (!prev_ov) begin
            if (expq.size() == 0) fail("unexpected_out_valid");
            else if (expq[0].lat >= 0)
              chk("latency", cyc - expq[0].t0, expq[0].lat);
          end
          if (rdy_hold > 0) begin
            out_ready = 1'b0;
            rdy_hold--;
          end else begin
            out_ready = fast || ($urandom_range(0, 3) != 0);
          end
          if (out_ready && expq.size() != 0) begin
            e = expq.pop_front();
            chk("ir_out", ir_out, e.ir);
            chk("rd_out", rd_out, e.rd);
            chk("a_out", a_out, e.a);
            chk("pc_out", pc_out, e.pc);
            chk("err_out", err_out, e.err);
          end
          h_ir = ir_out;
          h_rd = rd_out;
          h_a = a_out;
          h_pc = pc_out;
        end else begin
          out_ready = 1'b0;
        end
        prev_ov = out_valid;
        prev_rdy = out_ready;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    logic [31:0] rnd;
    logic [31:0] i;
    logic [31:0] a;
    logic [2:0]  f;
    logic [6:0]  op;
    int          r;
    int          base;
    rst_n = 1'b0;
    in_valid = 1'b0;
    ir = 32'b0;
    addr = 32'b0;
    wdata = 32'b0;
    pc = 32'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {out_valid, mem_req, err_out}, 3'b000);
    chk("rst_rd", rd_out, 32'b0);
    chk("rst_ir", ir_out, 32'b0);
    chk("rst_maddr", 32'(mem_addr), 32'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    fast = 1;
    preload_w(32'h100, 32'hDEADBEEF);
    issue({12'h0, 5'd0, 3'd2, 5'd1, 7'h03}, 32'h100, 32'h0, 32'h1000);
    drain();
    preload_w(32'h100, 32'h80112233);
    issue({12'h0, 5'd0, 3'd0, 5'd1, 7'h03}, 32'h103, 32'h0, 32'h1004);
    issue({12'h0, 5'd0, 3'd4, 5'd1, 7'h03}, 32'h103, 32'h0, 32'h1008);
    drain();
    issue({7'h0, 5'd2, 5'd1, 3'd2, 5'd0, 7'h23}, 32'h102, 32'h11223344, 32'h100c);
    issue({12'h0, 5'd0, 3'd2, 5'd1, 7'h03}, 32'h100, 32'h0, 32'h1010);
    issue({12'h0, 5'd0, 3'd2, 5'd1, 7'h03}, 32'h104, 32'h0, 32'h1014);
    drain();
    preload_b(32'h3FFFF, 8'hAA);
    preload_b(32'h0, 8'h55);
    gnt_hold = 5;
    issue({12'h0, 5'd0, 3'd1, 5'd3, 7'h03}, 32'h3FFFF, 32'h0, 32'h1018);
    drain();
    rdy_hold = 4;
    issue(32'h00B50533, 32'h1234, 32'h0, 32'h101c);
    drain();
    rdy_hold = 4;
    issue({12'h0, 5'd2, 3'd3, 5'd5, 7'h03}, 32'h200, 32'h0, 32'h1020);
    drain();

    gnt_hold = 100;
    issue({12'h0, 5'd0, 3'd2, 5'd1, 7'h03}, 32'h200, 32'h0, 32'h1024);
    chk("pre_rst_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", mem_req, 1'b0);
    chk("rst_idle", in_ready, 1'b1);
    expq.delete();
    accq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    gnt_hold = 0;
    @(negedge clk);

    hold_rv = 1;
    issue({12'h0, 5'd0, 3'd2, 5'd1, 7'h03}, 32'h300, 32'h0, 32'h1028);
    t = 0;
    while (accq.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("wait0_timeout");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_w_req", mem_req, 1'b0);
    chk("rst_w_ov", out_valid, 1'b0);
    expq.delete();
    accq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    hold_rv = 0;
    force_rv = 1;
    @(negedge clk);
    #2 force_rv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #3;
      chk("late_rv_ov", out_valid, 1'b0);
      chk("late_rv_rdy", in_ready, 1'b1);
    end
    @(negedge clk);

    fast = 0;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        op = 7'h03;
        f = ld_f3[$urandom_range(0, 4)];
      end else if (r < 8) begin
        op = 7'h23;
        f = 3'($urandom_range(0, 2));
      end else begin
        op = alu_op[$urandom_range(0, 2)];
        f = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       base = 0;
        1:       base = 32'h3FFF8;
        default: base = 32'h100;
      endcase
      rnd = $urandom;
      a = (rnd & 32'hFFFC0000) |
          (32'(base + $urandom_range(0, 7)) & 32'(BMASK));
      i = $urandom;
      i[6:0] = op;
      i[14:12] = f;
      issue(i, a, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    chk("exp_left", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
